// File: rtl/tr5_button_irq_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tr5_button_irq_sequencer
//
// Hardware stand-in for a button ISR. It masters the 4-bit button PIO over
// Avalon-MM. After reset it programs the PIO interrupt mask. On every PIO
// interrupt it reads edge_capture, then data, and clears edge_capture. It
// then queues {level, edges} in a small event FIFO, which a downstream
// consumer drains over a valid/ready stream.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   pio_address         PIO register address (0 data, 2 irq_mask, 3 edge_capture)
//   pio_chipselect      PIO select
//   pio_write_n         PIO write strobe, active low
//   pio_writedata       PIO write data (bits 31:4 always zero)
//   pio_readdata        PIO registered read data (bits 3:0 used)
//   pio_irq             PIO level interrupt
//   cfg_mask            new interrupt mask
//   cfg_mask_wr         pulse: latch cfg_mask and schedule a mask write
//   ev_data             FIFO head entry {level[3:0], edges[3:0]}
//   ev_valid            FIFO not empty
//   ev_ready            consumer accepts the head entry
//   overflow_cnt        dropped events, saturating at 255
//   busy                sequencer is not idle
// ---------------------------------------------------------------------------
module tr5_button_irq_sequencer #(
    parameter logic [3:0] DEFAULT_MASK = 4'hF,
    parameter int         FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata,
    input  logic [31:0] pio_readdata,
    input  logic        pio_irq,
    input  logic [3:0]  cfg_mask,
    input  logic        cfg_mask_wr,
    output logic [7:0]  ev_data,
    output logic        ev_valid,
    input  logic        ev_ready,
    output logic [7:0]  overflow_cnt,
    output logic        busy
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [3:0] {
        S_INIT,
        S_IDLE,
        S_MASK,
        S_RD_EDGE,
        S_WT_EDGE,
        S_RD_LVL,
        S_WT_LVL,
        S_CLEAR,
        S_PUSH
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [1:0]    addr_c;
    logic          cs_c;
    logic          wn_c;
    logic [3:0]    wd_c;

    logic [3:0]    edges;
    logic [3:0]    level;
    logic [3:0]    mask_latched;
    logic          mask_pending;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    ovf_q;

    logic          fifo_full;
    logic          pop;
    logic          push;
    logic          drop;

    // Only the low nibble of the PIO read data carries button state.
    logic          readdata_unused;
    assign readdata_unused = ^pio_readdata[31:4];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and bus decode. Reads use two cycles: the address cycle,
    // then a wait cycle in which the PIO's registered readdata is valid.
    // Chipselect is asserted only in the address cycle, so each register
    // is read once.
    always_comb begin
        state_nxt = state;
        addr_c    = 2'd0;
        cs_c      = 1'b0;
        wn_c      = 1'b1;
        wd_c      = 4'd0;
        unique case (state)
            S_INIT: begin
                addr_c    = 2'd2;
                cs_c      = 1'b1;
                wn_c      = 1'b0;
                wd_c      = DEFAULT_MASK;
                state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (mask_pending) begin
                    state_nxt = S_MASK;
                end else if (pio_irq) begin
                    state_nxt = S_RD_EDGE;
                end
            end
            S_MASK: begin
                addr_c    = 2'd2;
                cs_c      = 1'b1;
                wn_c      = 1'b0;
                wd_c      = mask_latched;
                state_nxt = S_IDLE;
            end
            S_RD_EDGE: begin
                addr_c    = 2'd3;
                cs_c      = 1'b1;
                state_nxt = S_WT_EDGE;
            end
            S_WT_EDGE: begin
                addr_c    = 2'd3;
                state_nxt = (pio_readdata[3:0] == 4'd0) ? S_IDLE : S_RD_LVL;
            end
            S_RD_LVL: begin
                addr_c    = 2'd0;
                cs_c      = 1'b1;
                state_nxt = S_WT_LVL;
            end
            S_WT_LVL: begin
                addr_c    = 2'd0;
                state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                addr_c    = 2'd3;
                cs_c      = 1'b1;
                wn_c      = 1'b0;
                state_nxt = S_PUSH;
            end
            S_PUSH: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_INIT;
            end
        endcase
    end

    // While reset is held the state sits in INIT. Gating with reset keeps
    // the bus quiet until reset is released.
    assign pio_chipselect = cs_c & ~reset;
    assign pio_write_n    = wn_c | reset;
    assign pio_address    = reset ? 2'd0 : addr_c;
    assign pio_writedata  = reset ? 32'd0 : {28'd0, wd_c};
    assign busy           = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            edges <= 4'd0;
            level <= 4'd0;
        end else begin
            if (state == S_WT_EDGE) begin
                edges <= pio_readdata[3:0];
            end
            if (state == S_WT_LVL) begin
                level <= pio_readdata[3:0];
            end
        end
    end

    // A new request wins over the MASK-state clear. A request that
    // arrives during MASK therefore still gets its own write.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_latched <= 4'd0;
            mask_pending <= 1'b0;
        end else if (cfg_mask_wr) begin
            mask_latched <= cfg_mask;
            mask_pending <= 1'b1;
        end else if (state == S_MASK) begin
            mask_pending <= 1'b0;
        end
    end

    // A pop in the same cycle frees a slot, so a push into a full FIFO
    // still succeeds when the consumer is draining.
    assign fifo_full = (count == FULL_COUNT);
    assign pop       = ev_valid & ev_ready;
    assign push      = (state == S_PUSH) & (~fifo_full | pop);
    assign drop      = (state == S_PUSH) & fifo_full & ~pop;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {level, edges};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 8'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (drop && (ovf_q != 8'hFF)) begin
                ovf_q <= ovf_q + 8'd1;
            end
        end
    end

    assign ev_valid     = (count != '0);
    assign ev_data      = ev_valid ? fifo_mem[rd_ptr] : 8'h00;
    assign overflow_cnt = ovf_q;

endmodule
